// File: rtl/fix_field_parser.sv
// fix_field_parser: splits an inbound FIX byte stream into tag=value fields, frames on tag 8/10, checks CheckSum.
// Latency: every output is registered, 1 cycle after the accepting edge. Backpressure: none, one byte per enable.
// Optional feature FIX_SEMICOLON_DELIM_EN: ';' (0x3B) is also a field delimiter.
module fix_field_parser #(
   parameter int TAG_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [7:0]       din,
   output logic [TAG_W-1:0] tag,
   output logic             val_valid,
   output logic [7:0]       val_data,
   output logic             field_done,
   output logic             msg_start,
   output logic             msg_end,
   output logic             chk_ok,
   output logic             chk_err,
   output logic             fmt_err
);

   localparam logic [7:0]       SOH        = 8'h01;
   localparam logic [7:0]       EQ         = 8'h3D;
   localparam logic [TAG_W-1:0] TAG_BEGIN  = TAG_W'(8);
   localparam logic [TAG_W-1:0] TAG_CHKSUM = TAG_W'(10);
   localparam logic [TAG_W-1:0] TAG_MAX    = {TAG_W{1'b1}};

   typedef enum logic [1:0] {
      ST_TAG   = 2'd0,
      ST_VALUE = 2'd1,
      ST_SKIP  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [TAG_W-1:0] tag_acc_q, tag_acc_d;
   logic             tag_any_q, tag_any_d;
   logic             fld_first_q, fld_first_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             in_msg_q, in_msg_d;
   logic [7:0]       sum_q, sum_d;
   logic [7:0]       snap_q, snap_d;
   logic [9:0]       cval_q, cval_d;
   logic [2:0]       ccnt_q, ccnt_d;
   logic             cbad_q, cbad_d;

   logic             val_valid_q, val_valid_d;
   logic [7:0]       val_data_q, val_data_d;
   logic             field_done_q, field_done_d;
   logic             msg_start_q, msg_start_d;
   logic             msg_end_q, msg_end_d;
   logic             chk_ok_q, chk_ok_d;
   logic             chk_err_q, chk_err_d;
   logic             fmt_err_q, fmt_err_d;

   logic             is_delim;
   logic             is_digit;
   logic [3:0]       dig;
   logic [TAG_W+3:0] tag_ext;
   logic [TAG_W+3:0] tag_mul;
   logic [TAG_W-1:0] tag_sat;
   logic [9:0]       cval_mul;
   logic             chk_match;

   always_comb begin
      is_delim = (din == SOH);
`ifdef FIX_SEMICOLON_DELIM_EN
      is_delim = is_delim || (din == 8'h3B);
`endif
   end

   // ASCII digits carry their value in the low nibble.
   always_comb begin
      is_digit  = (din >= 8'h30) && (din <= 8'h39);
      dig       = din[3:0];
      tag_ext   = {4'b0000, tag_acc_q};
      tag_mul   = (tag_ext << 3) + (tag_ext << 1) + {{TAG_W{1'b0}}, dig};
      tag_sat   = (tag_mul[TAG_W+3:TAG_W] != 4'b0000) ? TAG_MAX : tag_mul[TAG_W-1:0];
      cval_mul  = (cval_q << 3) + (cval_q << 1) + {6'b000000, dig};
      chk_match = (ccnt_q == 3'd3) && !cbad_q && (cval_q == {2'b00, snap_q});
   end

   always_comb begin
      state_d      = state_q;
      tag_acc_d    = tag_acc_q;
      tag_any_d    = tag_any_q;
      fld_first_d  = fld_first_q;
      tag_d        = tag_q;
      in_msg_d     = in_msg_q;
      sum_d        = sum_q;
      snap_d       = snap_q;
      cval_d       = cval_q;
      ccnt_d       = ccnt_q;
      cbad_d       = cbad_q;
      val_valid_d  = 1'b0;
      val_data_d   = val_data_q;
      field_done_d = 1'b0;
      msg_start_d  = 1'b0;
      msg_end_d    = 1'b0;
      chk_ok_d     = 1'b0;
      chk_err_d    = 1'b0;
      fmt_err_d    = 1'b0;

      if (enable) begin
         sum_d = sum_q + din;
         // Outside a message each field restarts the sum so tag 8 opens from its own first byte.
         if (state_q == ST_TAG && fld_first_q) begin
            snap_d = sum_q;
            if (!in_msg_q) begin
               sum_d = din;
            end
         end

         unique case (state_q)
            ST_TAG: begin
               fld_first_d = 1'b0;
               if (is_delim) begin
                  fmt_err_d   = 1'b1;
                  tag_acc_d   = '0;
                  tag_any_d   = 1'b0;
                  fld_first_d = 1'b1;
               end else if (is_digit) begin
                  tag_acc_d = tag_sat;
                  tag_any_d = 1'b1;
               end else if (din == EQ && tag_any_q) begin
                  tag_d     = tag_acc_q;
                  state_d   = ST_VALUE;
                  tag_acc_d = '0;
                  tag_any_d = 1'b0;
                  cval_d    = '0;
                  ccnt_d    = '0;
                  cbad_d    = 1'b0;
               end else begin
                  fmt_err_d = 1'b1;
                  state_d   = ST_SKIP;
                  tag_acc_d = '0;
                  tag_any_d = 1'b0;
               end
            end

            ST_VALUE: begin
               if (is_delim) begin
                  field_done_d = 1'b1;
                  state_d      = ST_TAG;
                  fld_first_d  = 1'b1;
                  if (tag_q == TAG_BEGIN) begin
                     msg_start_d = 1'b1;
                     in_msg_d    = 1'b1;
                     // Restart inside a message: keep only this tag-8 field's bytes.
                     if (in_msg_q) begin
                        fmt_err_d = 1'b1;
                        sum_d     = sum_q + din - snap_q;
                     end
                  end else if (!in_msg_q) begin
                     fmt_err_d = 1'b1;
                  end else if (tag_q == TAG_CHKSUM) begin
                     msg_end_d = 1'b1;
                     in_msg_d  = 1'b0;
                     chk_ok_d  = chk_match;
                     chk_err_d = !chk_match;
                  end
               end else begin
                  val_valid_d = 1'b1;
                  val_data_d  = din;
                  if (is_digit) begin
                     cval_d = cval_mul;
                     if (ccnt_q != 3'd7) begin
                        ccnt_d = ccnt_q + 3'd1;
                     end
                  end else begin
                     cbad_d = 1'b1;
                  end
               end
            end

            ST_SKIP: begin
               if (is_delim) begin
                  state_d     = ST_TAG;
                  fld_first_d = 1'b1;
               end
            end

            default: begin
               state_d = ST_TAG;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_TAG;
         tag_acc_q    <= '0;
         tag_any_q    <= 1'b0;
         fld_first_q  <= 1'b1;
         tag_q        <= '0;
         in_msg_q     <= 1'b0;
         sum_q        <= '0;
         snap_q       <= '0;
         cval_q       <= '0;
         ccnt_q       <= '0;
         cbad_q       <= 1'b0;
         val_valid_q  <= 1'b0;
         val_data_q   <= '0;
         field_done_q <= 1'b0;
         msg_start_q  <= 1'b0;
         msg_end_q    <= 1'b0;
         chk_ok_q     <= 1'b0;
         chk_err_q    <= 1'b0;
         fmt_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         tag_acc_q    <= tag_acc_d;
         tag_any_q    <= tag_any_d;
         fld_first_q  <= fld_first_d;
         tag_q        <= tag_d;
         in_msg_q     <= in_msg_d;
         sum_q        <= sum_d;
         snap_q       <= snap_d;
         cval_q       <= cval_d;
         ccnt_q       <= ccnt_d;
         cbad_q       <= cbad_d;
         val_valid_q  <= val_valid_d;
         val_data_q   <= val_data_d;
         field_done_q <= field_done_d;
         msg_start_q  <= msg_start_d;
         msg_end_q    <= msg_end_d;
         chk_ok_q     <= chk_ok_d;
         chk_err_q    <= chk_err_d;
         fmt_err_q    <= fmt_err_d;
      end
   end

   assign tag        = tag_q;
   assign val_valid  = val_valid_q;
   assign val_data   = val_data_q;
   assign field_done = field_done_q;
   assign msg_start  = msg_start_q;
   assign msg_end    = msg_end_q;
   assign chk_ok     = chk_ok_q;
   assign chk_err    = chk_err_q;
   assign fmt_err    = fmt_err_q;

endmodule
